ips_hsst_sync_filter_v1_0: RTL

Multi-channel, parametrised successor to the single-bit two-flop synchroniser used in the HSST pipe. It brings WIDTH independent asynchronous level signals (PLL lock, CDR lock, signal-detect, rx-idle, reset-done) into one clock domain through an STAGES-deep flop chain per channel. Each channel also has a stability filter that rejects post-sync pulses shorter than FILTER_CNT cycles. Per-channel rise and fall strobes are provided for the HSST reset/bring-up FSMs.

---
 rtl/ips_hsst_sync_filter_v1_0_pkg.sv | 22 ++
 rtl/ips_hsst_sync_filter_ch_v1_0.sv | 81 ++++++++
 rtl/ips_hsst_sync_filter_v1_0.sv | 45 ++++
 3 files changed

// File: rtl/ips_hsst_sync_filter_v1_0_pkg.sv
// ---------------------------------------------------------------------------
// ips_hsst_sync_filter_v1_0_pkg
// Shared helpers for the HSST level synchroniser / stability filter.
//   cnt_width(n) : counter width for a filter depth of n, i.e. clog2(n)
//                  but never less than one bit.
// ---------------------------------------------------------------------------
package ips_hsst_sync_filter_v1_0_pkg;

   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((32'd1 << k) < n) begin
            w = k + 32'd1;
         end else begin
            w = w;
         end
      end
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage : ips_hsst_sync_filter_v1_0_pkg

// File: rtl/ips_hsst_sync_filter_ch_v1_0.sv
// ---------------------------------------------------------------------------
// ips_hsst_sync_filter_ch_v1_0
// One channel: STAGES-deep synchroniser chain, stability filter that only
// accepts a new level after FILTER_CNT consecutive differing samples, and
// registered rise/fall strobes aligned with the filtered level update.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   sig_async_i  asynchronous level input
//   sig_synced_o synchronised, filtered level
//   sig_rise_o   one-cycle strobe on 0->1 of sig_synced_o
//   sig_fall_o   one-cycle strobe on 1->0 of sig_synced_o
// ---------------------------------------------------------------------------
module ips_hsst_sync_filter_ch_v1_0
   import ips_hsst_sync_filter_v1_0_pkg::*;
#(
   parameter int unsigned STAGES     = 2,
   parameter logic        RST_VAL    = 1'b0,
   parameter int unsigned FILTER_CNT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_async_i,
   output logic sig_synced_o,
   output logic sig_rise_o,
   output logic sig_fall_o
);

   localparam int unsigned      CNT_W   = cnt_width(FILTER_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 32'd1);

   // Metastability chain: keep the flops together and out of shift-register primitives.
   (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              chain_out;
   logic              synced_q;
   logic              synced_d;
   logic              rise_q;
   logic              fall_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   // Next-state for chain shift and the stability filter.
   always_comb begin
      sync_d    = {sync_q[STAGES-2:0], sig_async_i};
      chain_out = sync_q[STAGES-1];
      synced_d  = synced_q;
      cnt_d     = {CNT_W{1'b0}};
      if (chain_out == synced_q) begin
         // Any agreement restarts the run, so short pulses are forgotten.
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
         synced_d = chain_out;
         cnt_d    = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end
   end

   // State registers; strobes are derived from the same update as synced_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= {STAGES{RST_VAL}};
         synced_q <= RST_VAL;
         cnt_q    <= {CNT_W{1'b0}};
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         synced_q <= synced_d;
         cnt_q    <= cnt_d;
         rise_q   <= ~synced_q & synced_d;
         fall_q   <= synced_q & ~synced_d;
      end
   end

   assign sig_synced_o = synced_q;
   assign sig_rise_o   = rise_q;
   assign sig_fall_o   = fall_q;

endmodule : ips_hsst_sync_filter_ch_v1_0

// File: rtl/ips_hsst_sync_filter_v1_0.sv
// ---------------------------------------------------------------------------
// ips_hsst_sync_filter_v1_0
// WIDTH independent level synchronisers with stability filter and edge
// strobes, used to bring lock/detect/idle/done levels into the HSST clock.
// Ports:
//   clk        sole clock
//   rst        asynchronous active-high reset
//   sig_async  [WIDTH] asynchronous level inputs
//   sig_synced [WIDTH] synchronised, filtered levels
//   sig_rise   [WIDTH] one-cycle 0->1 strobes
//   sig_fall   [WIDTH] one-cycle 1->0 strobes
// ---------------------------------------------------------------------------
module ips_hsst_sync_filter_v1_0
   import ips_hsst_sync_filter_v1_0_pkg::*;
#(
   parameter int unsigned       WIDTH      = 4,
   parameter int unsigned       STAGES     = 2,
   parameter logic [WIDTH-1:0]  RST_VAL    = {WIDTH{1'b0}},
   parameter int unsigned       FILTER_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_async,
   output logic [WIDTH-1:0] sig_synced,
   output logic [WIDTH-1:0] sig_rise,
   output logic [WIDTH-1:0] sig_fall
);

   // Channels share nothing but clock and reset; no cross-bit coherency.
   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      ips_hsst_sync_filter_ch_v1_0 #(
         .STAGES     (STAGES),
         .RST_VAL    (RST_VAL[g]),
         .FILTER_CNT (FILTER_CNT)
      ) u_ch (
         .clk_i        (clk),
         .rst_i        (rst),
         .sig_async_i  (sig_async[g]),
         .sig_synced_o (sig_synced[g]),
         .sig_rise_o   (sig_rise[g]),
         .sig_fall_o   (sig_fall[g])
      );
   end

endmodule : ips_hsst_sync_filter_v1_0
